// File: rtl/alu_unit_buffered_pkg.sv
// taiga_config / taiga_types: default datapath width and the ALU issue encodings
// shared by decode, the ALU unit and the writeback path.
package taiga_config;
  localparam int XLEN = 32;
endpackage

package taiga_types;
  typedef enum logic [1:0] {ALU_ADD_SUB, ALU_SLT, ALU_SHIFT, ALU_MINMAX} alu_op_t;
  typedef enum logic [1:0] {ALU_LOGIC_ADD, ALU_LOGIC_XOR, ALU_LOGIC_OR, ALU_LOGIC_AND} alu_logic_op_t;
  typedef struct packed {
    alu_op_t       op;
    alu_logic_op_t logic_op;
    logic          subtract;
    logic          is_signed;
    logic          lshift;
    logic          max;
  } alu_ctrl_t;
  // Issue packet at the default configuration; parametrised units build their own width.
  typedef struct packed {
    alu_ctrl_t                   ctrl;
    logic [taiga_config::XLEN-1:0] in1;
    logic [taiga_config::XLEN-1:0] in2;
    logic [2:0]                  id;
  } alu_issue_t;
endpackage

// File: rtl/alu_unit_buffered_shifter.sv
// alu_barrel_shifter: log2(XLEN)-stage right shifter; fill_i supplies the vacated MSBs.
module alu_barrel_shifter #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]         data_i,
  input  logic [$clog2(XLEN)-1:0] shamt_i,
  input  logic                    fill_i,
  output logic [XLEN-1:0]         result_o
);
  localparam int SW = $clog2(XLEN);
  logic [XLEN-1:0] st [SW+1];
  assign st[0] = data_i;
  for (genvar k = 0; k < SW; k++) begin : g_stage
    assign st[k+1] = shamt_i[k] ? {{(2**k){fill_i}}, st[k][XLEN-1:2**k]} : st[k];
  end
  assign result_o = st[SW];
endmodule

// File: rtl/alu_unit_buffered.sv
// alu_unit_buffered: pipelined ALU with credit-gated, in-order tagged writeback FIFO.
// Define ALU_MINMAX_EN to implement op 11 as MIN/MAX; otherwise op 11 retires result 0.
module alu_unit_buffered
  import taiga_types::*;
#(
  parameter int XLEN    = taiga_config::XLEN,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 1,
  parameter int ID_W    = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [1:0]      issue_op,
  input  logic [1:0]      issue_logic_op,
  input  logic            issue_subtract,
  input  logic            issue_signed,
  input  logic            issue_lshift,
  input  logic            issue_max,
  input  logic [XLEN-1:0] issue_in1,
  input  logic [XLEN-1:0] issue_in2,
  input  logic [ID_W-1:0] issue_id,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_rd,
  output logic [ID_W-1:0] wb_id,
  input  logic            wb_ack
);
  localparam int SW = $clog2(XLEN);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    alu_ctrl_t       ctrl;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [ID_W-1:0] id;
  } issue_t;

  function automatic logic [XLEN-1:0] rev(input logic [XLEN-1:0] v);
    for (int i = 0; i < XLEN; i++) rev[i] = v[XLEN-1-i];
  endfunction

  logic accept, pop, ex_vld;
  issue_t req, ex;

  assign accept = issue_valid & issue_ready & ~flush;
  assign pop    = wb_valid & wb_ack & ~flush;
  assign req = '{ctrl: '{op: alu_op_t'(issue_op), logic_op: alu_logic_op_t'(issue_logic_op),
                         subtract: issue_subtract, is_signed: issue_signed,
                         lshift: issue_lshift, max: issue_max},
                 in1: issue_in1, in2: issue_in2, id: issue_id};

  if (LATENCY == 2) begin : g_stage
    issue_t stage_q;
    logic   stage_vld_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        stage_q     <= '0;
        stage_vld_q <= 1'b0;
      end else begin
        stage_vld_q <= accept;
        if (accept) stage_q <= req;
      end
    assign ex     = stage_q;
    assign ex_vld = stage_vld_q;
  end else begin : g_direct
    assign ex     = req;
    assign ex_vld = accept;
  end

  // One (XLEN+1)-bit subtractor serves SUB, SLT/SLTU and the MIN/MAX compare.
  logic            s1, s2, lt;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] sum, logic_res, sh_in, sh_out, shift_res, mm_res, res;

  assign s1   = ex.ctrl.is_signed & ex.in1[XLEN-1];
  assign s2   = ex.ctrl.is_signed & ex.in2[XLEN-1];
  assign diff = {s1, ex.in1} - {s2, ex.in2};
  assign lt   = diff[XLEN];
  assign sum  = ex.ctrl.subtract ? diff[XLEN-1:0] : ex.in1 + ex.in2;
  assign logic_res = ex.ctrl.logic_op == ALU_LOGIC_XOR ? ex.in1 ^ ex.in2 :
                     ex.ctrl.logic_op == ALU_LOGIC_OR  ? ex.in1 | ex.in2 :
                     ex.ctrl.logic_op == ALU_LOGIC_AND ? ex.in1 & ex.in2 : sum;

  assign sh_in     = ex.ctrl.lshift ? rev(ex.in1) : ex.in1;
  assign shift_res = ex.ctrl.lshift ? rev(sh_out) : sh_out;

  alu_barrel_shifter #(.XLEN(XLEN)) u_shifter (
    .data_i  (sh_in),
    .shamt_i (ex.in2[SW-1:0]),
    .fill_i  (ex.ctrl.is_signed & ~ex.ctrl.lshift & ex.in1[XLEN-1]),
    .result_o(sh_out)
  );

`ifdef ALU_MINMAX_EN
  assign mm_res = (ex.ctrl.max ^ lt) ? ex.in1 : ex.in2;
`else
  logic unused_max;
  assign unused_max = ex.ctrl.max;
  assign mm_res     = '0;
`endif

  assign res = ex.ctrl.op == ALU_SLT    ? XLEN'(lt) :
               ex.ctrl.op == ALU_SHIFT  ? shift_res :
               ex.ctrl.op == ALU_MINMAX ? mm_res    : logic_res;

  logic [XLEN-1:0] rd_mem [DEPTH];
  logic [ID_W-1:0] id_mem [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d, occ_q, occ_d;

  // occ counts in-flight plus buffered entries, so the FIFO itself never overflows.
  assign issue_ready = occ_q < CW'(DEPTH);
  assign wb_valid    = cnt_q != '0;
  assign wb_rd       = wb_valid ? rd_mem[rd_q] : '0;
  assign wb_id       = wb_valid ? id_mem[rd_q] : '0;

  always_comb begin
    wr_d  = flush ? '0 : !ex_vld ? wr_q : wr_q == PW'(DEPTH - 1) ? '0 : wr_q + PW'(1);
    rd_d  = flush ? '0 : !pop ? rd_q : rd_q == PW'(DEPTH - 1) ? '0 : rd_q + PW'(1);
    cnt_d = flush ? '0 : cnt_q + CW'(ex_vld) - CW'(pop);
    occ_d = flush ? '0 : occ_q + CW'(accept) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      occ_q <= occ_d;
    end

  always_ff @(posedge clk)
    if (ex_vld) begin
      rd_mem[wr_q] <= res;
      id_mem[wr_q] <= ex.id;
    end
endmodule

// File: tb/tb_alu_unit_buffered.sv
// tb_alu_unit_buffered: directed and randomised checks of the 32-bit/LATENCY=1 unit
// plus a 64-bit/LATENCY=2 instance for the latency and width cases.
module tb_alu_unit_buffered;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic        flush = 0, issue_valid = 0, issue_ready;
  logic [1:0]  issue_op = 0, issue_logic_op = 0;
  logic        issue_subtract = 0, issue_signed = 0, issue_lshift = 0, issue_max = 0;
  logic [31:0] issue_in1 = 0, issue_in2 = 0, wb_rd;
  logic [2:0]  issue_id = 0, wb_id;
  logic        wb_valid, wb_ack = 0;

  logic        b_flush = 0, b_issue_valid = 0, b_issue_ready;
  logic [1:0]  b_issue_op = 0, b_issue_logic_op = 0;
  logic        b_issue_subtract = 0, b_issue_signed = 0, b_issue_lshift = 0, b_issue_max = 0;
  logic [63:0] b_issue_in1 = 0, b_issue_in2 = 0, b_wb_rd;
  logic [2:0]  b_issue_id = 0, b_wb_id;
  logic        b_wb_valid, b_wb_ack = 0;

  alu_unit_buffered #(.XLEN(32), .DEPTH(4), .LATENCY(1), .ID_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_logic_op(issue_logic_op), .issue_subtract(issue_subtract),
    .issue_signed(issue_signed), .issue_lshift(issue_lshift), .issue_max(issue_max),
    .issue_in1(issue_in1), .issue_in2(issue_in2), .issue_id(issue_id),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_id(wb_id), .wb_ack(wb_ack));

  alu_unit_buffered #(.XLEN(64), .DEPTH(4), .LATENCY(2), .ID_W(3)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .issue_valid(b_issue_valid), .issue_ready(b_issue_ready),
    .issue_op(b_issue_op), .issue_logic_op(b_issue_logic_op), .issue_subtract(b_issue_subtract),
    .issue_signed(b_issue_signed), .issue_lshift(b_issue_lshift), .issue_max(b_issue_max),
    .issue_in1(b_issue_in1), .issue_in2(b_issue_in2), .issue_id(b_issue_id),
    .wb_valid(b_wb_valid), .wb_rd(b_wb_rd), .wb_id(b_wb_id), .wb_ack(b_wb_ack));

  int passes = 0, total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_req(input logic [1:0] op, input logic [1:0] lo, input logic sub, input logic sgn,
                         input logic lsh, input logic mx, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] id);
    issue_valid = 1; issue_op = op; issue_logic_op = lo; issue_subtract = sub;
    issue_signed = sgn; issue_lshift = lsh; issue_max = mx;
    issue_in1 = a; issue_in2 = b; issue_id = id;
  endtask

  task automatic run_one(input string tag, input logic [1:0] op, input logic [1:0] lo, input logic sub,
                         input logic sgn, input logic lsh, input logic mx, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    set_req(op, lo, sub, sgn, lsh, mx, a, b, 3'd5);
    wb_ack = 1;
    @(negedge clk);
    issue_valid = 0;
    chk({tag, "_vld"}, 64'(wb_valid), 64'd1);
    chk(tag, 64'(wb_rd), 64'(exp));
    @(negedge clk);
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [1:0] lo, input logic sub,
                                        input logic sgn, input logic lsh, input logic mx,
                                        input logic [31:0] a, input logic [31:0] b);
    logic lt;
    lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
    case (op)
      2'd0: model = lo == 2'd1 ? a ^ b : lo == 2'd2 ? a | b : lo == 2'd3 ? a & b : sub ? a - b : a + b;
      2'd1: model = {31'd0, lt};
      2'd2: model = lsh ? a << b[4:0] : sgn ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
`ifdef ALU_MINMAX_EN
      default: model = mx ? (lt ? b : a) : (lt ? a : b);
`else
      default: model = 32'd0;
`endif
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [34:0] exp_q[$];
    logic acc_now, pop_now, fl_now;
    int acc;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(issue_ready), 64'd1);
    chk("rst_valid", 64'(wb_valid), 64'd0);
    chk("rst_rd", 64'(wb_rd), 64'd0);
    chk("rst_id", 64'(wb_id), 64'd0);
    chk("rst64_valid", 64'(b_wb_valid), 64'd0);
    rst_n = 1;
    @(negedge clk);

    // in-order back-to-back retirement with the arbiter always accepting
    wb_ack = 1;
    set_req(2'd0, 2'd0, 0, 0, 0, 0, 32'd3, 32'd7, 3'd1);
    @(negedge clk);
    chk("seq_add_vld", 64'(wb_valid), 64'd1);
    chk("seq_add", 64'(wb_rd), 64'h0000000a);
    chk("seq_add_id", 64'(wb_id), 64'd1);
    set_req(2'd0, 2'd0, 1, 0, 0, 0, 32'd3, 32'd7, 3'd2);
    @(negedge clk);
    chk("seq_sub", 64'(wb_rd), 64'hfffffffc);
    chk("seq_sub_id", 64'(wb_id), 64'd2);
    set_req(2'd0, 2'd1, 1, 0, 0, 0, 32'hff00ff00, 32'h0f0f0f0f, 3'd3);
    @(negedge clk);
    issue_valid = 0;
    chk("seq_xor", 64'(wb_rd), 64'hf00ff00f);
    chk("seq_xor_id", 64'(wb_id), 64'd3);
    @(negedge clk);
    chk("seq_empty", 64'(wb_valid), 64'd0);

    // fill to DEPTH with writeback stalled, then one ack frees one credit a cycle later
    wb_ack = 0;
    for (int k = 0; k < 4; k++) begin
      set_req(2'd0, 2'd0, 0, 0, 0, 0, 32'(k + 1), 32'd10, 3'(k));
      chk($sformatf("full_rdy%0d", k), 64'(issue_ready), 64'd1);
      @(negedge clk);
    end
    set_req(2'd0, 2'd0, 0, 0, 0, 0, 32'd5, 32'd10, 3'd4);
    chk("full_notrdy", 64'(issue_ready), 64'd0);
    chk("full_head", 64'(wb_rd), 64'd11);
    wb_ack = 1;
    @(negedge clk);
    wb_ack = 0;
    chk("full_rdy_after_ack", 64'(issue_ready), 64'd1);
    @(negedge clk);
    issue_valid = 0;
    chk("full_refill", 64'(issue_ready), 64'd0);
    wb_ack = 1;
    for (int j = 1; j <= 4; j++) begin
      chk($sformatf("drain_rd%0d", j), 64'(wb_rd), 64'(11 + j));
      chk($sformatf("drain_id%0d", j), 64'(wb_id), 64'(j));
      @(negedge clk);
    end
    chk("drain_empty", 64'(wb_valid), 64'd0);

    run_one("slt", 2'd1, 2'd0, 0, 1, 0, 0, 32'h80000000, 32'h00000001, 32'd1);
    run_one("sltu", 2'd1, 2'd0, 0, 0, 0, 0, 32'h80000000, 32'h00000001, 32'd0);
    run_one("slt_pos", 2'd1, 2'd0, 0, 1, 0, 0, 32'h00000003, 32'h00000007, 32'd1);
    run_one("sll", 2'd2, 2'd0, 0, 0, 1, 0, 32'h21212121, 32'd7, 32'h90909080);
    run_one("srl", 2'd2, 2'd0, 0, 0, 0, 0, 32'h81818181, 32'd14, 32'h00020606);
    run_one("sra", 2'd2, 2'd0, 0, 1, 0, 0, 32'h80000000, 32'd31, 32'hffffffff);
    run_one("sh_mask", 2'd2, 2'd0, 0, 0, 0, 0, 32'h80000000, 32'h25, 32'h04000000);
    run_one("or", 2'd0, 2'd2, 1, 0, 0, 0, 32'hf0f00000, 32'h000f0f00, 32'hf0ff0f00);
    run_one("and", 2'd0, 2'd3, 0, 0, 0, 0, 32'hf0f0f0f0, 32'h3c3c3c3c, 32'h30303030);
`ifdef ALU_MINMAX_EN
    run_one("max", 2'd3, 2'd0, 0, 1, 0, 1, 32'hffffffff, 32'h00000001, 32'h00000001);
    run_one("maxu", 2'd3, 2'd0, 0, 0, 0, 1, 32'hffffffff, 32'h00000001, 32'hffffffff);
`else
    run_one("op11_max", 2'd3, 2'd0, 0, 1, 0, 1, 32'hffffffff, 32'h00000001, 32'h00000000);
    run_one("op11_maxu", 2'd3, 2'd0, 0, 0, 0, 1, 32'hffffffff, 32'h00000001, 32'h00000000);
`endif

    // flush with three buffered; the request and ack in the flush cycle are dropped
    wb_ack = 0;
    for (int k = 0; k < 3; k++) begin
      set_req(2'd0, 2'd0, 0, 0, 0, 0, 32'(k), 32'd1, 3'(k + 1));
      @(negedge clk);
    end
    set_req(2'd0, 2'd0, 0, 0, 0, 0, 32'd9, 32'd9, 3'd7);
    flush = 1; wb_ack = 1;
    @(negedge clk);
    flush = 0; issue_valid = 0; wb_ack = 0;
    chk("flush_vld", 64'(wb_valid), 64'd0);
    chk("flush_rdy", 64'(issue_ready), 64'd1);
    repeat (3) @(negedge clk);
    chk("flush_no_ghost", 64'(wb_valid), 64'd0);
    run_one("post_flush", 2'd0, 2'd0, 0, 0, 0, 0, 32'd40, 32'd2, 32'd42);

    // asynchronous reset with two results held
    wb_ack = 0;
    set_req(2'd0, 2'd0, 0, 0, 0, 0, 32'd1, 32'd1, 3'd1);
    @(negedge clk);
    set_req(2'd0, 2'd0, 0, 0, 0, 0, 32'd2, 32'd2, 3'd2);
    @(negedge clk);
    issue_valid = 0;
    chk("pre_rst_vld", 64'(wb_valid), 64'd1);
    #2 rst_n = 0;
    #1;
    chk("arst_vld", 64'(wb_valid), 64'd0);
    chk("arst_rdy", 64'(issue_ready), 64'd1);
    chk("arst_rd", 64'(wb_rd), 64'd0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("arst_no_stale", 64'(wb_valid), 64'd0);

    // random ops, random stalls and occasional flush against the reference model
    acc = 0;
    for (int c = 0; c < 8000 && acc < 1000; c++) begin
      chk("rnd_vld", 64'(wb_valid), 64'(exp_q.size() != 0));
      chk("rnd_rdy", 64'(issue_ready), 64'(exp_q.size() < 4));
      if (wb_valid && exp_q.size() != 0) begin
        chk("rnd_rd", 64'(wb_rd), 64'(exp_q[0][31:0]));
        chk("rnd_id", 64'(wb_id), 64'(exp_q[0][34:32]));
      end
      set_req(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), $urandom,
              $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40)), 3'($urandom));
      issue_valid = $urandom_range(0, 3) != 0;
      wb_ack = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 63) == 0;
      fl_now = flush;
      acc_now = issue_valid && issue_ready && !flush;
      pop_now = wb_valid && wb_ack && !flush;
      @(negedge clk);
      if (fl_now) exp_q.delete();
      else begin
        if (pop_now) void'(exp_q.pop_front());
        if (acc_now) begin
          exp_q.push_back({issue_id, model(issue_op, issue_logic_op, issue_subtract, issue_signed,
                                           issue_lshift, issue_max, issue_in1, issue_in2)});
          acc++;
        end
      end
    end
    chk("rnd_count", 64'(acc), 64'd1000);
    issue_valid = 0; flush = 0; wb_ack = 1;
    for (int c = 0; c < 8 && exp_q.size() != 0; c++) begin
      chk("rnd_drain_rd", 64'(wb_rd), 64'(exp_q[0][31:0]));
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    chk("rnd_drained", 64'(wb_valid), 64'd0);

    // 64-bit, two-cycle latency instance
    b_wb_ack = 1;
    b_issue_valid = 1; b_issue_op = 0; b_issue_logic_op = 0; b_issue_subtract = 0;
    b_issue_in1 = 64'h00000001_ffffffff; b_issue_in2 = 64'd1; b_issue_id = 3'd1;
    @(negedge clk);
    chk("l2_not_yet", 64'(b_wb_valid), 64'd0);
    b_issue_subtract = 1; b_issue_in1 = 64'd3; b_issue_in2 = 64'd7; b_issue_id = 3'd2;
    @(negedge clk);
    chk("l2_vld", 64'(b_wb_valid), 64'd1);
    chk("l2_add", b_wb_rd, 64'h00000002_00000000);
    chk("l2_add_id", 64'(b_wb_id), 64'd1);
    b_issue_subtract = 0; b_issue_logic_op = 2'd1; b_issue_id = 3'd3;
    b_issue_in1 = 64'hff00ff00_ff00ff00; b_issue_in2 = 64'h0f0f0f0f_0f0f0f0f;
    @(negedge clk);
    b_issue_valid = 0;
    chk("l2_sub", b_wb_rd, 64'hffffffff_fffffffc);
    chk("l2_sub_id", 64'(b_wb_id), 64'd2);
    @(negedge clk);
    chk("l2_xor", b_wb_rd, 64'hf00ff00f_f00ff00f);
    chk("l2_xor_id", 64'(b_wb_id), 64'd3);
    @(negedge clk);
    chk("l2_empty", 64'(b_wb_valid), 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/alu_unit_buffered.md
# alu_unit_buffered

Parametrised successor to the single-issue ALU execution unit.

- Executes add/sub, bitwise logic, set-less-than and shifts at configurable width XLEN.
- Has a fixed configurable pipeline latency.
- Buffers results in an internal writeback FIFO with tagged valid/ack retirement, so the writeback arbiter can stall without blocking issue until the buffer is full.
- Sits between decode/issue and the writeback mux.

## Interface

Clock/reset: one clock; reset is asynchronous and active-low.

Parameters:
- XLEN, 32: operand/result width (≥8, power of two).
- DEPTH, 4: maximum results in flight plus buffered (2–16).
- LATENCY, 1: issue-to-FIFO cycles, 1 or 2 (2 adds a register after operand decode).
- ID_W, 3: width of the passthrough instruction tag.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous discard of all in-flight and buffered results
- issue_valid  in  1  request present
- issue_ready  out  1  unit can accept a request this cycle
- issue_op  in  2  00 ADD_SUB/LOGIC, 01 SLT, 10 SHIFT, 11 MINMAX
- issue_logic_op  in  2  00 add, 01 xor, 10 or, 11 and (ADD_SUB only)
- issue_subtract  in  1  subtract (ADD_SUB with logic_op=00)
- issue_signed  in  1  SLT vs SLTU, SRA vs SRL, MIN/MAX vs MINU/MAXU
- issue_lshift  in  1  left shift (SHIFT)
- issue_max  in  1  select max (MINMAX)
- issue_in1, issue_in2  in  XLEN  operands
- issue_id  in  ID_W  tag
- wb_valid  out  1  FIFO head valid
- wb_rd  out  XLEN  head result
- wb_id  out  ID_W  head tag
- wb_ack  in  1  head consumed this cycle

## Operation

- Accept on issue_valid & issue_ready.
- Results leave strictly in issue order.
- ADD_SUB:
  - logic_op=00 gives in1±in2, mod 2^XLEN.
  - Logic ops ignore subtract.
- SLT:
  - Compute (XLEN+1)-bit {s,in1}−{s,in2}, where s = issue_signed ? operand MSB : 0.
  - Result is the zero-extended sign bit.
- SHIFT:
  - Amount is in2[log2(XLEN)-1:0]; upper bits ignored.
  - Left shift: reverse in1, right-shift, reverse back.
  - Right shift: fill with in1 MSB iff issue_signed.
- MINMAX: see Configuration.
- Credit counter `occ` = in-flight + buffered, range 0..DEPTH.
  - issue_ready = (occ < DEPTH).
  - No combinational path from wb_ack to issue_ready.
- occ update per cycle: +1 on accept, −1 on wb_valid & wb_ack. Simultaneous accept and ack leaves occ unchanged.
- FIFO: circular, DEPTH entries, pointers wrap modulo DEPTH. It cannot overflow because credit gating prevents it.
- wb_ack while wb_valid=0 is ignored.
- flush:
  - Next cycle: occ=0, FIFO empty, pipeline valids cleared.
  - A request presented in the flush cycle is dropped.
  - wb_ack in the flush cycle is ignored.
- Reset values: issue_ready=1, wb_valid=0, wb_rd=0, wb_id=0, occ=0, pointers=0.
- Reset asserted mid-operation discards everything immediately (asynchronous).

## Timing

- Accept at edge N gives the result in the FIFO at edge N+LATENCY.
- If the FIFO was empty, wb_valid=1 in the cycle after edge N+LATENCY.
- Throughput: one op per cycle while occ<DEPTH.
- Full: with occ=DEPTH and wb_ack=1, issue_ready rises the following cycle (one-cycle bubble, by design).
- wb_rd/wb_id are stable while wb_valid=1 and wb_ack=0.
- Head advances on the edge where wb_valid & wb_ack.

## Configuration

- ALU_MINMAX_EN defined:
  - op 11 yields issue_max ? larger : smaller of in1/in2.
  - Comparison is signed iff issue_signed.
  - Reuses the SLT subtractor.
- ALU_MINMAX_EN undefined:
  - op 11 is reserved and produces result 0 (still retires with its tag).
  - No comparator mux is built.

## Structure

- Shared package taiga_types holds:
  - alu_op_t (2-bit enum: ALU_ADD_SUB, ALU_SLT, ALU_SHIFT, ALU_MINMAX)
  - alu_logic_op_t
  - packed alu_issue_t (op fields + operands + id)
- taiga_config holds the default XLEN.
- Sub-module alu_barrel_shifter (XLEN, log2 stages, right shift with arith fill) is instantiated once.
- The FIFO is kept inline.

## Test plan

1. Sequence and full/drain:
   - Stimulus: XLEN=32, LATENCY=1, wb_ack held 1; issue ADD 3+7, SUB 3−7, XOR ff00ff00^0f0f0f0f on consecutive cycles.
   - Expected: wb_rd 0000000a, fffffffc, f00ff00f on three consecutive cycles, tags in order.
   - Then hold wb_ack=0 and issue 5 requests (DEPTH=4): issue_ready falls after the 4th accept; one ack gives issue_ready=1 on the next cycle; the 5th result follows the first four.
2. SLT/SLTU:
   - SLT 80000000 vs 00000001 → 1.
   - SLTU same operands → 0.
   - SLT 00000003 vs 00000007 → 1.
3. Shifts:
   - SLL 21212121 by 7 → 90909080.
   - SRL 81818181 by 14 → 00020606.
   - SRA 80000000 by 31 → ffffffff.
   - Shift amount 0x25 → shift by 5.
4. Backpressure plus random flush:
   - Random ack stalls with 1000 random ops checked against a reference model.
   - Flush with 3 buffered: next cycle wb_valid=0, issue_ready=1; the request in the flush cycle never appears.
5. MINMAX:
   - With ALU_MINMAX_EN: MAX signed ffffffff/00000001 → 00000001; MAXU → ffffffff.
   - Without the macro: op 11 → 00000000.
6. Reset and latency:
   - rst_n low mid-stream with 2 in flight: wb_valid=0 asynchronously, issue_ready=1, no stale results after release.
   - Repeat case 1 at LATENCY=2 and XLEN=64: first wb_valid one cycle later, 64-bit sums correct.
